// File: rtl/rsa_modexp_core.sv
// Montgomery modular exponentiation o_result = a^d mod n, exponent scanned LSB first.
// Latency WIDTH + passes*(WIDTH+1) + 1 cycles; no backpressure, i_abort cancels at any time.
module rsa_modexp_core #(
  parameter int WIDTH         = 256,
  parameter int EXP_BITS      = 256,
  parameter int PARALLEL_MONT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [WIDTH-1:0]    i_a,
  input  logic [EXP_BITS-1:0] i_d,
  input  logic [WIDTH-1:0]    i_n,
  output logic                o_busy,
  output logic                o_done,
  output logic [WIDTH-1:0]    o_result
);

  localparam int CW = $clog2(WIDTH);
  localparam int KW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam int SW = WIDTH + 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(EXP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MONT, S_UPDATE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [KW-1:0]       k_q, k_d;
  logic [WIDTH:0]      r_q, r_d;
  logic [WIDTH-1:0]    n_q, n_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WIDTH-1:0]    t_q, t_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [EXP_BITS-1:0] d_q, d_d;
  logic [SW-1:0]       sa_q, sa_d;
  logic [SW-1:0]       sb_q, sb_d;
  logic                mul_q, mul_d;
  logic [WIDTH:0]      r_dbl;
  logic                xa_bit;
  logic                adv;

  function automatic logic [SW-1:0] mont_step(input logic [SW-1:0] s, input logic xb,
                                              input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] md);
    logic [SW-1:0] acc;
    acc = s + (xb ? {2'b00, y} : {SW{1'b0}});
    if (acc[0]) acc = acc + {2'b00, md};
    return acc >> 1;
  endfunction

  function automatic logic [WIDTH-1:0] mont_reduce(input logic [SW-1:0] s, input logic [WIDTH-1:0] md);
    logic [SW-1:0] diff;
    diff = s - {2'b00, md};
    return (s >= {2'b00, md}) ? diff[WIDTH-1:0] : s[WIDTH-1:0];
  endfunction

  assign r_dbl  = {r_q[WIDTH-1:0], 1'b0};
  // Unit A's multiplier operand is m unless the shared unit is running a squaring pass.
  assign xa_bit = (PARALLEL_MONT != 0 || mul_q) ? m_q[cnt_q] : t_q[cnt_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    r_d      = r_q;
    n_d      = n_q;
    m_d      = m_q;
    t_d      = t_q;
    result_d = result_q;
    d_d      = d_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    mul_d    = mul_q;
    adv      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_d = S_PREP;
          r_d     = {1'b0, i_a};
          d_d     = i_d;
          n_d     = i_n;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      S_PREP: begin
        r_d   = (r_dbl >= {1'b0, n_q}) ? (r_dbl - {1'b0, n_q}) : r_dbl;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_MONT;
          cnt_d   = '0;
          t_d     = r_d[WIDTH-1:0];
          m_d     = WIDTH'(1);
          sa_d    = '0;
          sb_d    = '0;
          mul_d   = d_q[0];
        end
      end
      S_MONT: begin
        sa_d = mont_step(sa_q, xa_bit, t_q, n_q);
        if (PARALLEL_MONT != 0) sb_d = mont_step(sb_q, t_q[cnt_q], t_q, n_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_UPDATE;
          cnt_d   = '0;
        end
      end
      S_UPDATE: begin
        sa_d = '0;
        sb_d = '0;
        if (PARALLEL_MONT != 0) begin
          if (d_q[k_q]) m_d = mont_reduce(sa_q, n_q);
          t_d = mont_reduce(sb_q, n_q);
          adv = 1'b1;
        end else if (mul_q) begin
          m_d   = mont_reduce(sa_q, n_q);
          mul_d = 1'b0;
        end else begin
          t_d = mont_reduce(sa_q, n_q);
          adv = 1'b1;
        end
        if (!adv) begin
          state_d = S_MONT;
        end else if (k_q == K_LAST) begin
          state_d  = S_DONE;
          result_d = m_d;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_MONT;
          mul_d   = d_q[k_d];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over completion; a pulse already showing in DONE is left alone.
    if (state_q != S_IDLE && i_abort) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      r_q      <= '0;
      n_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      result_q <= '0;
      d_q      <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      mul_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      r_q      <= r_d;
      n_q      <= n_d;
      m_q      <= m_d;
      t_q      <= t_d;
      result_q <= result_d;
      d_q      <= d_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      mul_q    <= mul_d;
    end
  end

  assign o_busy   = (state_q == S_PREP) || (state_q == S_MONT) || (state_q == S_UPDATE);
  assign o_done   = (state_q == S_DONE);
  assign o_result = result_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: four instances (8/16 bit, parallel/shared unit) against a cycle-count and arithmetic model.
module tb_rsa_modexp_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       start, abort;
  logic [3:0][15:0] a_in, d_in, n_in;
  logic [3:0]       busy_v, done_v;
  logic [7:0]       res0, res1;
  logic [15:0]      res2, res3;
  logic [3:0][15:0] res_w;

  assign res_w = {res3, res2, 8'd0, res1, 8'd0, res0};

  rsa_modexp_core #(.WIDTH(8), .EXP_BITS(8), .PARALLEL_MONT(1)) u_p8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
    .i_a(a_in[0][7:0]), .i_d(d_in[0][7:0]), .i_n(n_in[0][7:0]),
    .o_busy(busy_v[0]), .o_done(done_v[0]), .o_result(res0));
  rsa_modexp_core #(.WIDTH(8), .EXP_BITS(8), .PARALLEL_MONT(0)) u_s8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
    .i_a(a_in[1][7:0]), .i_d(d_in[1][7:0]), .i_n(n_in[1][7:0]),
    .o_busy(busy_v[1]), .o_done(done_v[1]), .o_result(res1));
  rsa_modexp_core #(.WIDTH(16), .EXP_BITS(16), .PARALLEL_MONT(1)) u_p16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .i_abort(abort[2]),
    .i_a(a_in[2]), .i_d(d_in[2]), .i_n(n_in[2]),
    .o_busy(busy_v[2]), .o_done(done_v[2]), .o_result(res2));
  rsa_modexp_core #(.WIDTH(16), .EXP_BITS(16), .PARALLEL_MONT(0)) u_s16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[3]), .i_abort(abort[3]),
    .i_a(a_in[3]), .i_d(d_in[3]), .i_n(n_in[3]),
    .o_busy(busy_v[3]), .o_done(done_v[3]), .o_result(res3));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int cfg_w(input int j);
    return (j < 2) ? 8 : 16;
  endfunction

  function automatic bit cfg_par(input int j);
    return (j % 2) == 0;
  endfunction

  function automatic longint ref_modexp(input longint a, input longint d, input longint n, input int eb);
    longint r, b;
    r = 1;
    b = a;
    for (int i = 0; i < eb; i++) begin
      if (d[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return r;
  endfunction

  function automatic int lat_fn(input int j, input longint d);
    int w, p;
    w = cfg_w(j);
    p = 0;
    if (!cfg_par(j))
      for (int i = 0; i < w; i++) p += int'(d[i]);
    return w + (w + p) * (w + 1) + 1;
  endfunction

  // Model: per instance, whether a run is live, its cycle number, its expected latency and result.
  bit     m_act  [4];
  int     m_cyc  [4];
  int     m_lat  [4];
  longint m_res  [4];
  longint m_held [4];

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      longint mask;
      mask = (longint'(1) << cfg_w(j)) - 1;
      if (!rst_n) begin
        m_act[j]  = 1'b0;
        m_held[j] = 0;
      end else if (m_act[j] && m_cyc[j] == m_lat[j]) begin
        m_act[j] = 1'b0;
      end else if (m_act[j] && abort[j]) begin
        m_act[j] = 1'b0;
      end else if (m_act[j]) begin
        m_cyc[j]++;
        if (m_cyc[j] == m_lat[j]) m_held[j] = m_res[j];
      end else if (start[j] && !abort[j]) begin
        m_act[j] = 1'b1;
        m_cyc[j] = 1;
        m_lat[j] = lat_fn(j, longint'(d_in[j]) & mask);
        m_res[j] = ref_modexp(longint'(a_in[j]) & mask, longint'(d_in[j]) & mask,
                              longint'(n_in[j]) & mask, cfg_w(j));
      end
    end
    #1;
    if (chk_en) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("dut%0d busy", j), longint'(busy_v[j]), longint'(m_act[j] && m_cyc[j] < m_lat[j]));
        chk($sformatf("dut%0d done", j), longint'(done_v[j]), longint'(m_act[j] && m_cyc[j] == m_lat[j]));
        chk($sformatf("dut%0d result", j), longint'(res_w[j]), m_held[j]);
      end
    end
  end

  // Starts one run; optionally pulses i_start again, or ends it early with abort or reset.
  task automatic run(input int j, input longint a, input longint d, input longint n,
                     input int pulse_at, input int stop_at, input bit use_rst,
                     output longint res, output int lat);
    int cyc, budget;
    bit fin;
    budget = lat_fn(j, d) + 8;
    @(negedge clk);
    a_in[j]  = a[15:0];
    d_in[j]  = d[15:0];
    n_in[j]  = n[15:0];
    start[j] = 1'b1;
    cyc = 0;
    fin = 1'b0;
    res = -1;
    lat = -1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start[j] = (cyc == pulse_at);
      a_in[j]  = 16'($urandom);
      d_in[j]  = 16'($urandom);
      n_in[j]  = 16'($urandom);
      if (done_v[j]) begin
        res = longint'(res_w[j]);
        lat = cyc;
        fin = 1'b1;
      end else if (cyc == stop_at) begin
        if (use_rst) rst_n = 1'b0;
        else abort[j] = 1'b1;
        fin = 1'b1;
      end else if (cyc > budget) begin
        checks++;
        errors++;
        $display("FAIL dut%0d timeout: no o_done after %0d cycles, required by cycle %0d", j, cyc, budget - 8);
        fin = 1'b1;
      end
    end
  endtask

  task automatic rand_runs(input int j, input int count);
    longint a, d, n, res;
    int lat, w;
    w = cfg_w(j);
    for (int i = 0; i < count; i++) begin
      n = 2 * longint'($urandom_range(1, (1 << (w - 1)) - 1)) + 1;
      a = longint'($urandom_range(0, 32'(n - 1)));
      d = longint'($urandom) & ((longint'(1) << w) - 1);
      run(j, a, d, n, -1, -1, 1'b0, res, lat);
      chk($sformatf("dut%0d rand result a=%0d d=%0d n=%0d", j, a, d, n), res, ref_modexp(a, d, n, w));
      chk($sformatf("dut%0d rand latency d=%0d", j, d), longint'(lat), longint'(lat_fn(j, d)));
    end
  endtask

  initial begin
    longint res;
    int lat;
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    a_in  = '0;
    d_in  = '0;
    n_in  = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("dut%0d reset busy", j), longint'(busy_v[j]), 0);
      chk($sformatf("dut%0d reset done", j), longint'(done_v[j]), 0);
      chk($sformatf("dut%0d reset result", j), longint'(res_w[j]), 0);
    end
    rst_n = 1'b1;

    chk("model 5^3 mod 143", ref_modexp(5, 3, 143, 8), 125);
    chk("model 2^10 mod 253", ref_modexp(2, 10, 253, 8), 12);
    chk("model 7^0 mod 143", ref_modexp(7, 0, 143, 8), 1);
    chk("model 4^13 mod 497", ref_modexp(4, 13, 497, 16), 445);
    chk("model latency par8", longint'(lat_fn(0, 3)), 81);
    chk("model latency ser8 d=3", longint'(lat_fn(1, 3)), 99);
    chk("model latency ser8 d=0", longint'(lat_fn(1, 0)), 81);

    run(0, 5, 3, 143, -1, -1, 1'b0, res, lat);
    chk("par8 5^3 result", res, 125);
    chk("par8 5^3 done cycle", longint'(lat), 81);
    run(0, 2, 10, 253, -1, -1, 1'b0, res, lat);
    chk("par8 2^10 result", res, 12);
    chk("par8 2^10 done cycle", longint'(lat), 81);
    run(0, 7, 0, 143, -1, -1, 1'b0, res, lat);
    chk("par8 d=0 result", res, 1);
    run(0, 0, 9, 143, -1, -1, 1'b0, res, lat);
    chk("par8 a=0 result", res, 0);

    run(1, 5, 3, 143, -1, -1, 1'b0, res, lat);
    chk("ser8 5^3 result", res, 125);
    chk("ser8 5^3 done cycle", longint'(lat), 99);
    run(1, 7, 0, 143, -1, -1, 1'b0, res, lat);
    chk("ser8 d=0 result", res, 1);
    chk("ser8 d=0 done cycle", longint'(lat), 81);
    run(1, 2, 10, 253, 20, -1, 1'b0, res, lat);
    chk("ser8 mid-run start result", res, 12);
    chk("ser8 mid-run start done cycle", longint'(lat), 99);

    run(2, 4, 13, 497, -1, -1, 1'b0, res, lat);
    chk("par16 4^13 result", res, 445);
    chk("par16 4^13 done cycle", longint'(lat), 289);
    run(3, 4, 13, 497, -1, -1, 1'b0, res, lat);
    chk("ser16 4^13 result", res, 445);
    chk("ser16 4^13 done cycle", longint'(lat), 340);

    run(0, 5, 3, 143, -1, -1, 1'b0, res, lat);
    chk("par8 pre-abort result", res, 125);
    run(0, 2, 10, 253, -1, 30, 1'b0, res, lat);
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort busy next cycle", longint'(busy_v[0]), 0);
    chk("abort no done", longint'(done_v[0]), 0);
    chk("abort result held", longint'(res_w[0]), 125);
    run(0, 2, 10, 253, -1, -1, 1'b0, res, lat);
    chk("post-abort result", res, 12);
    chk("post-abort done cycle", longint'(lat), 81);

    run(3, 5, 3, 143, -1, 40, 1'b1, res, lat);
    @(negedge clk);
    chk("reset busy", longint'(busy_v[3]), 0);
    chk("reset done", longint'(done_v[3]), 0);
    chk("reset result dut3", longint'(res_w[3]), 0);
    chk("reset result dut0", longint'(res_w[0]), 0);
    rst_n = 1'b1;
    run(3, 4, 13, 497, -1, -1, 1'b0, res, lat);
    chk("post-reset result", res, 445);
    chk("post-reset done cycle", longint'(lat), 340);

    fork
      rand_runs(0, 300);
      rand_runs(1, 200);
      rand_runs(2, 70);
      rand_runs(3, 45);
    join

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
